// File: rtl/stream_mux_nx1.sv
// stream_mux_nx1: registered N-to-1 stream mux with valid/ready handshake,
// fixed-select or round-robin arbitration, and grant held until a packet's last beat.
module stream_mux_nx1 #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state, state_nxt;
    logic [SEL_W-1:0] lock_ch, rr_ptr, g;
    logic gv, can_load, acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lock_ch <= '0;
            rr_ptr  <= SEL_W'(N_CH - 1);
        end else begin
            state <= state_nxt;
            if (acc && state == IDLE) begin
                lock_ch <= g;
                if (mode) rr_ptr <= g;
            end
        end
    end

    always_comb state_nxt = acc ? (in_last[g] ? IDLE : LOCK) : state;

    // Loop runs from the lowest priority down so the nearest valid channel after rr_ptr wins.
    always_comb begin
        g  = '0;
        gv = 1'b0;
        if (state == LOCK) begin
            g  = lock_ch;
            gv = 1'b1;
        end else if (!mode) begin
            g  = sel;
            gv = (int'(sel) < N_CH) && in_valid[sel];
        end else begin
            for (int i = N_CH; i >= 1; i--)
                if (in_valid[(int'(rr_ptr) + i) % N_CH]) begin
                    g  = SEL_W'((int'(rr_ptr) + i) % N_CH);
                    gv = 1'b1;
                end
        end
        can_load = !out_valid || out_ready;
        acc      = rst_n && gv && can_load && in_valid[g];
        in_ready = '0;
        if (rst_n && gv) in_ready[g] = can_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else begin
            out_valid <= acc || (out_valid && !out_ready);
            if (acc) begin
                out_data <= in_data[int'(g)*WIDTH +: WIDTH];
                out_last <= in_last[g];
                out_ch   <= g;
            end
        end
    end
endmodule
